ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit sitting directly upstream of the instruction cache and downstream of the memory controller. Each cycle it drives the cache lookup with the current PC. On a hit it hands the instruction (32-bit or RVC 16-bit) to the decoder through a one-entry output register and advances the PC by 4 or 2. On a miss it fetches 4 bytes from memory, writes them into the cache with the compressed flag, and retries. A redirect from the back end (branch/jump/exception) flushes the output and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0, PC loaded on reset
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; when low all state, including outputs, is frozen
- icache_get_ready  out  1  lookup request valid
- icache_get_addr  out  32  lookup address (= pc)
- hit  in  1  cache hit for icache_get_addr, same cycle
- icache_get_inst  in  32  cached instruction, same cycle
- icache_get_is_c  in  1  cached entry is compressed
- wr_ready  out  1  cache fill strobe, one cycle
- wr_is_c  out  1  fill entry is compressed
- wr_addr  out  32  fill address
- wr_inst  out  32  fill data
- mem_req  out  1  memory read request, held until mem_done
- mem_addr  out  32  read address (halfword aligned; controller returns 4 bytes)
- mem_done  in  1  one-cycle pulse, mem_data valid
- mem_data  in  32  little-endian bytes mem_addr..mem_addr+3
- flush_in  in  1  redirect request
- flush_pc  in  32  redirect target
- inst_valid  out  1  output register holds an instruction
- inst_ready  in  1  decoder accepts this cycle
- inst  out  32  instruction; upper 16 bits zero when compressed
- inst_pc  out  32  address of inst
- inst_is_c  out  1  inst is RVC

## Operation
- Registers: pc, miss_addr, state {FETCH, MISS, FILL}, output register.
- Compressed detect: is_c = (data[1:0] != 2'b11); fill data = is_c ? {16'h0, data[15:0]} : data.
- FETCH: icache_get_ready = 1 when out_free = !inst_valid || inst_ready, and flush_in = 0. If hit: load output (inst, pc, is_c), pc += is_c ? 2 : 4 (mod 2^32). If miss: miss_addr <= pc, go to MISS.
- MISS: mem_req = 1, mem_addr = miss_addr. On mem_done, latch data, go to FILL.
- FILL: wr_ready = 1, wr_addr = miss_addr, wr_inst/wr_is_c from the latched data. Go to FETCH. The fill never loads the output; the retry hits.
- Output: inst_valid clears on inst_ready when no new load; it stays set with new contents on simultaneous load and accept.
- Flush (highest priority): pc <= flush_pc, inst_valid <= 0, and no lookup or output load occurs that cycle.
  - In FETCH: state stays in FETCH.
  - In MISS: state stays; the outstanding request completes and fills the cache for miss_addr, then fetch resumes at the new pc. A request is never abandoned.
  - Flush coincident with mem_done or during FILL: the fill proceeds normally and pc takes flush_pc.
- rdy_in = 0: no register changes; mem_req/mem_addr held; wr_ready is effectively ignored by the cache.

## Timing
- Reset (async): pc = RESET_PC, state = FETCH, and every output is 0 (icache_get_addr = RESET_PC since it mirrors pc).
- Hit path: lookup in cycle N gives inst_valid in N+1. Throughput is one instruction per cycle while the decoder accepts.
- Miss path: lookup miss in cycle N gives mem_req from N+1. A mem_done in cycle M gives FILL in M+1, hit lookup in M+2 and inst_valid in M+3.
- Backpressure: with inst_valid = 1 and inst_ready = 0, no lookup is issued and pc is stable.

## Structure
- Shared package holds the state enum, INST_LEN = 4, C_LEN = 2, and the is_compressed function (reused by the decoder).
- No sub-module; the FSM and output register live in one module.

## Test plan
- Cold miss at RESET_PC = 0, memory returns 32'h00500093 after 3 cycles -> mem_req/mem_addr = 0 for 3 cycles. Then wr_ready with wr_is_c = 0. Then inst_valid with inst = 32'h00500093, inst_pc = 0, next pc = 4.
- Compressed entry 32'hXXXX4505 at pc 8 -> inst = 32'h00004505, inst_is_c = 1, next icache_get_addr = 10. Cross-check wr_inst on the fill.
- Hit stream of 4 instructions with inst_ready low for 2 cycles mid-stream -> no lookup while stalled; none lost or duplicated; inst_pc sequence 0, 4, 8, 12.
- Flush to 32'h100 while in MISS for 0x40 -> fill written for 0x40; no instruction from 0x40 delivered; next lookup at 0x100.
- Flush coincident with a hit and inst_ready = 1 -> inst_valid = 0 next cycle and pc = flush_pc.
- Async reset mid-MISS, plus rdy_in low for 3 cycles during FILL -> reset immediately zeros outputs. With rdy_in low, wr_ready stays asserted and the state is unchanged until rdy_in returns.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared fetch definitions: FSM state encoding, instruction lengths and RVC detection.
// The decoder imports the same is_compressed helper.
package ifetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        FILL  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_LEN = 32'd4;
    localparam logic [31:0] C_LEN    = 32'd2;

    function automatic logic is_compressed(input logic [31:0] data);
        return data[1:0] != 2'b11;
    endfunction

    // Compressed entries are stored with the upper halfword cleared.
    function automatic logic [31:0] fill_word(input logic [31:0] data);
        return is_compressed(data) ? {16'h0000, data[15:0]} : data;
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: drives I-cache lookups, refills the cache from memory on a miss,
// and hands instructions to the decoder through a one-entry output register.
//
// state | meaning
// FETCH | look up pc in the cache each cycle the output register can take a result
// MISS  | memory read of miss_addr outstanding; mem_req held until mem_done
// FILL  | one-cycle cache write of the latched memory word, then retry the lookup
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic        icache_get_ready,
    output logic [31:0] icache_get_addr,
    input  logic        hit,
    input  logic [31:0] icache_get_inst,
    input  logic        icache_get_is_c,

    output logic        wr_ready,
    output logic        wr_is_c,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_inst,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,

    input  logic        flush_in,
    input  logic [31:0] flush_pc,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  miss_addr;
    logic [31:0]  fill_data;
    logic         fill_is_c;

    logic         out_free;
    logic         lookup;
    logic         load;
    logic [31:0]  pc_step;

    assign out_free = !inst_valid || inst_ready;
    // Reset and rdy_in gate the strobe so no lookup is presented while the unit is held.
    assign lookup   = (state == FETCH) && out_free && !flush_in && rdy_in && !rst_in;
    assign load     = lookup && hit;
    assign pc_step  = icache_get_is_c ? C_LEN : INST_LEN;

    assign icache_get_ready = lookup;
    assign icache_get_addr  = pc;

    assign mem_req  = (state == MISS);
    assign mem_addr = miss_addr;

    assign wr_ready = (state == FILL);
    assign wr_addr  = miss_addr;
    assign wr_inst  = fill_data;
    assign wr_is_c  = fill_is_c;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            miss_addr  <= 32'h0;
            fill_data  <= 32'h0;
            fill_is_c  <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_is_c  <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                pc <= flush_pc;
            end else if (load) begin
                pc <= pc + pc_step;
            end

            // An outstanding memory read always completes and fills, even across a flush.
            case (state)
                FETCH: begin
                    if (lookup && !hit) begin
                        miss_addr <= pc;
                        state     <= MISS;
                    end
                end
                MISS: begin
                    if (mem_done) begin
                        fill_data <= fill_word(mem_data);
                        fill_is_c <= is_compressed(mem_data);
                        state     <= FILL;
                    end
                end
                FILL: begin
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase

            if (flush_in) begin
                inst_valid <= 1'b0;
            end else if (load) begin
                inst_valid <= 1'b1;
                inst       <= icache_get_is_c ? {16'h0000, icache_get_inst[15:0]} : icache_get_inst;
                inst_pc    <= pc;
                inst_is_c  <= icache_get_is_c;
            end else if (inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: bench-owned I-cache and memory models, hand-computed expectations.
module tb_ifetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_get_ready;
    logic [31:0] icache_get_addr;
    logic        hit;
    logic [31:0] icache_get_inst;
    logic        icache_get_is_c;
    logic        wr_ready;
    logic        wr_is_c;
    logic [31:0] wr_addr;
    logic [31:0] wr_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    ifetch #(.RESET_PC(32'h0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .icache_get_ready(icache_get_ready),
        .icache_get_addr (icache_get_addr),
        .hit             (hit),
        .icache_get_inst (icache_get_inst),
        .icache_get_is_c (icache_get_is_c),
        .wr_ready        (wr_ready),
        .wr_is_c         (wr_is_c),
        .wr_addr         (wr_addr),
        .wr_inst         (wr_inst),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_done        (mem_done),
        .mem_data        (mem_data),
        .flush_in        (flush_in),
        .flush_pc        (flush_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_is_c       (inst_is_c)
    );

    // Cache model: direct-mapped on addr[9:1] with full-address tag, plus a bench preload port.
    logic        cv   [512];
    logic [31:0] ctag [512];
    logic [31:0] cdat [512];
    logic        cc   [512];
    logic        cache_clr;
    logic        pl_we;
    logic        pl_v;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;
    logic [8:0]  cidx;

    assign cidx = icache_get_addr[9:1];

    always_comb begin
        hit             = cv[cidx] && (ctag[cidx] == icache_get_addr);
        icache_get_inst = cdat[cidx];
        icache_get_is_c = cc[cidx];
    end

    always @(posedge clk_in) begin
        if (cache_clr) begin
            for (int k = 0; k < 512; k++) cv[k] <= 1'b0;
        end else if (wr_ready && rdy_in) begin
            cv[wr_addr[9:1]]   <= 1'b1;
            ctag[wr_addr[9:1]] <= wr_addr;
            cdat[wr_addr[9:1]] <= wr_inst;
            cc[wr_addr[9:1]]   <= wr_is_c;
        end else if (pl_we) begin
            cv[pl_addr[9:1]]   <= pl_v;
            ctag[pl_addr[9:1]] <= pl_addr;
            cdat[pl_addr[9:1]] <= pl_data;
            cc[pl_addr[9:1]]   <= 1'b0;
        end
    end

    // Memory model: mem_done pulses in the third cycle of mem_req.
    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h000: return 32'h0050_0093;
            32'h008: return 32'h4585_4505;
            32'h020: return 32'h0090_0393;
            32'h040: return 32'h0070_0293;
            32'h100: return 32'h0080_0313;
            default: return 32'h0000_0013;
        endcase
    endfunction

    int mem_cnt;
    always @(posedge clk_in) begin
        if (rst_in) begin
            mem_cnt  <= 0;
            mem_done <= 1'b0;
            mem_data <= 32'h0;
        end else begin
            mem_done <= 1'b0;
            if (mem_req && rdy_in && !mem_done) begin
                if (mem_cnt >= 1) begin
                    mem_done <= 1'b1;
                    mem_data <= memword(mem_addr);
                    mem_cnt  <= 0;
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_fill(input logic [31:0] a, input logic [31:0] d, input logic c);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check1("fill_seen", wr_ready, 1'b1);
        check("fill_addr", wr_addr, a);
        check("fill_inst", wr_inst, d);
        check1("fill_is_c", wr_is_c, c);
    endtask

    task automatic wait_inst(input logic [31:0] p, input logic [31:0] d, input logic c);
        int n;
        n = 0;
        while (inst_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check1("inst_seen", inst_valid, 1'b1);
        check("inst_pc", inst_pc, p);
        check("inst", inst, d);
        check1("inst_is_c", inst_is_c, c);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_v = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = 32'h0;
        inst_ready = 1'b1; cache_clr = 1'b1; pl_we = 1'b0; pl_v = 1'b0;
        pl_addr = 32'h0; pl_data = 32'h0;
        step();
        cache_clr = 1'b0;
        preload(32'h04, 32'h0010_0113);
        preload(32'h08, 32'h0020_0193);
        preload(32'h0C, 32'h0030_0213);
        preload(32'h10, 32'h0040_0293);

        // Reset state
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_get_ready", icache_get_ready, 1'b0);
        check("rst_get_addr", icache_get_addr, 32'h0);
        check("rst_inst", inst, 32'h0);

        // Cold miss at 0
        rst_in = 1'b0;
        #1 check1("cold_lookup", icache_get_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check1("cold_mem_req", mem_req, 1'b1);
            check("cold_mem_addr", mem_addr, 32'h0);
        end
        step();
        check1("cold_mem_req_drop", mem_req, 1'b0);
        check1("cold_wr_ready", wr_ready, 1'b1);
        check("cold_wr_addr", wr_addr, 32'h0);
        check("cold_wr_inst", wr_inst, 32'h0050_0093);
        check1("cold_wr_is_c", wr_is_c, 1'b0);
        step();
        check1("cold_retry_lookup", icache_get_ready, 1'b1);
        check1("cold_no_early_valid", inst_valid, 1'b0);
        step();
        check1("cold_valid", inst_valid, 1'b1);
        check("cold_inst", inst, 32'h0050_0093);
        check("cold_inst_pc", inst_pc, 32'h0);
        check("cold_next_pc", icache_get_addr, 32'h4);

        // Hit stream with a two-cycle decoder stall
        step();
        check("s_pc4", inst_pc, 32'h4);
        check("s_inst4", inst, 32'h0010_0113);
        inst_ready = 1'b0;
        #1 check1("s_stall_lookup1", icache_get_ready, 1'b0);
        step();
        check1("s_stall_valid", inst_valid, 1'b1);
        check("s_stall_pc", inst_pc, 32'h4);
        check("s_stall_addr", icache_get_addr, 32'h8);
        check1("s_stall_lookup2", icache_get_ready, 1'b0);
        step();
        check("s_stall_pc2", inst_pc, 32'h4);
        inst_ready = 1'b1;
        #1 check1("s_resume_lookup", icache_get_ready, 1'b1);
        step();
        check("s_pc8", inst_pc, 32'h8);
        check("s_inst8", inst, 32'h0020_0193);
        step();
        check("s_pc12", inst_pc, 32'hC);
        check("s_inst12", inst, 32'h0030_0213);

        // Flush coincident with a hit and accept
        flush_in = 1'b1; flush_pc = 32'h40;
        #1 check1("fh_no_lookup", icache_get_ready, 1'b0);
        step();
        flush_in = 1'b0;
        check1("fh_valid_clear", inst_valid, 1'b0);
        check("fh_pc", icache_get_addr, 32'h40);

        // Flush while in MISS for 0x40
        step();
        check1("fm_mem_req", mem_req, 1'b1);
        flush_in = 1'b1; flush_pc = 32'h100;
        step();
        flush_in = 1'b0;
        check1("fm_req_held", mem_req, 1'b1);
        check("fm_mem_addr", mem_addr, 32'h40);
        check("fm_new_pc", icache_get_addr, 32'h100);
        wait_fill(32'h40, 32'h0070_0293, 1'b0);
        check1("fm_no_inst", inst_valid, 1'b0);
        step();
        check1("fm_lookup", icache_get_ready, 1'b1);
        check("fm_lookup_addr", icache_get_addr, 32'h100);
        wait_inst(32'h100, 32'h0080_0313, 1'b0);

        // Compressed entry at 8 (stale preload invalidated alongside the flush)
        flush_in = 1'b1; flush_pc = 32'h8;
        pl_we = 1'b1; pl_v = 1'b0; pl_addr = 32'h8; pl_data = 32'h0;
        step();
        flush_in = 1'b0; pl_we = 1'b0;
        check1("c_flush_clear", inst_valid, 1'b0);
        check("c_pc", icache_get_addr, 32'h8);
        wait_fill(32'h8, 32'h0000_4505, 1'b1);
        wait_inst(32'h8, 32'h0000_4505, 1'b1);
        check("c_next_pc", icache_get_addr, 32'hA);

        // Async reset mid-MISS
        step();
        check1("r_mem_req", mem_req, 1'b1);
        check("r_mem_addr", mem_addr, 32'hA);
        #2 rst_in = 1'b1;
        #1;
        check1("r_req_zero", mem_req, 1'b0);
        check("r_addr_zero", mem_addr, 32'h0);
        check1("r_valid_zero", inst_valid, 1'b0);
        check("r_pc_zero", icache_get_addr, 32'h0);
        check1("r_lookup_zero", icache_get_ready, 1'b0);
        step();
        rst_in = 1'b0;
        flush_in = 1'b1; flush_pc = 32'h20;
        step();
        flush_in = 1'b0;
        check("r_flush_pc", icache_get_addr, 32'h20);
        wait_fill(32'h20, 32'h0090_0393, 1'b0);

        // rdy_in low for three cycles during FILL
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check1("rdy_wr_held", wr_ready, 1'b1);
            check("rdy_wr_addr", wr_addr, 32'h20);
            check1("rdy_no_req", mem_req, 1'b0);
        end
        rdy_in = 1'b1;
        step();
        check1("rdy_fill_done", wr_ready, 1'b0);
        check("rdy_pc", icache_get_addr, 32'h20);
        #1 check1("rdy_lookup", icache_get_ready, 1'b1);
        wait_inst(32'h20, 32'h0090_0393, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
